// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU MEM stage and a
//   debug/loader port. The CPU normally wins. A debug request that has been
//   blocked for MAX_WAIT cycles is forced through, stalling the CPU for one
//   cycle. The cycle after a forced grant always belongs to the CPU, so
//   neither side can starve. Debug read data comes back registered, one cycle
//   after the grant.
//
//   Optional feature macro: DMEM_ARB_PERF_EN
//     defined   : saturating perf counters for stall cycles and debug grants
//     undefined : perf ports tied to 0, no counter flops
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cpu_*             CPU MEM stage request (req/wr_en/op/addr/wdata),
//                     cpu_rdata (combinational memory data), cpu_stall
//   dbg_*             debug request (valid/ready handshake, wr_en/op/addr/
//                     wdata), dbg_rvalid/dbg_rdata registered read return
//   mem_*             to/from data_memory (wr_en/op/addr/data_in, data_out)
//   perf_stall_cnt    cycles with cpu_stall=1
//   perf_dbg_cnt      number of debug grants
//
//   mem_op_t is carried as a plain OP_W-bit vector (size/sign encoding owned
//   by data_memory; the arbiter only steers it).
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16,
    parameter int OP_W     = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_wr_en,
    input  logic [OP_W-1:0]   cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_wr_en,
    input  logic [OP_W-1:0]   dbg_op,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_wr_en,
    output logic [OP_W-1:0]   mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_dbg_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {S_NORM, S_CPU_PRI} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              grant_dbg;

    // Debug gets the port when the CPU is idle, or when it has waited long
    // enough and the previous cycle was not itself a forced grant.
    assign grant_dbg = !reset && dbg_valid &&
                       (!cpu_req || (state == S_NORM && wait_cnt == WAIT_MAX));

    assign dbg_ready = grant_dbg;
    assign cpu_stall = cpu_req && grant_dbg;
    assign cpu_rdata = mem_data_out;

    // Memory port mux. A stalled CPU store is simply not selected, so it
    // cannot reach memory; it retries once the stall drops.
    always_comb begin
        mem_wr_en   = cpu_req && cpu_wr_en && !reset;
        mem_op      = cpu_op;
        mem_addr    = cpu_addr;
        mem_data_in = cpu_wdata;
        if (grant_dbg) begin
            mem_wr_en   = dbg_wr_en;
            mem_op      = dbg_op;
            mem_addr    = dbg_addr;
            mem_data_in = dbg_wdata;
        end
    end

    // FSM: one-cycle CPU-priority window after every forced grant.
    always_comb begin
        state_nxt = state;
        case (state)
            S_NORM:    if (cpu_req && grant_dbg) state_nxt = S_CPU_PRI;
            S_CPU_PRI: state_nxt = S_NORM;
            default:   state_nxt = S_NORM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_NORM;
            wait_cnt   <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state <= state_nxt;

            if (!dbg_valid || grant_dbg)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            // Memory read is combinational, so data at the grant is final.
            dbg_rvalid <= grant_dbg && !dbg_wr_en;
            if (grant_dbg && !dbg_wr_en)
                dbg_rdata <= mem_data_out;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, dbg_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            dbg_cnt_q   <= '0;
        end else begin
            if (cpu_stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (grant_dbg && dbg_cnt_q != '1)
                dbg_cnt_q <= dbg_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_dbg_cnt   = dbg_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_dbg_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Table-driven single-cycle vectors plus hand-written multi-cycle sequences
//   (starvation guard, stalled CPU store, reset mid-operation, perf counters).
//   A small word-addressed memory model stands in for data_memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr_en;
    logic [2:0]  cpu_op;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_ready, dbg_wr_en;
    logic [2:0]  dbg_op;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [15:0] perf_stall_cnt, perf_dbg_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .CNT_W(16), .OP_W(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_op(cpu_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wr_en(dbg_wr_en),
        .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .perf_stall_cnt(perf_stall_cnt), .perf_dbg_cnt(perf_dbg_cnt)
    );

    // Memory model: combinational read, write on rising edge.
    logic [31:0] mem [0:1023];
    assign mem_data_out = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr[11:2]] <= mem_data_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_valid = 1'b0; dbg_wr_en = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dv, dw;
        logic [31:0] da, dd;
        logic        e_rdy, e_stall, e_wr;
        logic [31:0] e_addr, e_din;
        logic [2:0]  e_op;
        logic [31:0] e_crd;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt [9];
    int   grant_at;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        cpu_op = 3'd2;
        dbg_op = 3'd5;
        idle_in();

        // ---- reset state: debug request held during reset must not be granted
        reset = 1'b1;
        dbg_valid = 1'b1; cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h900;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, dbg_ready}, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_memwr", {31'b0, mem_wr_en}, 32'd0);
        chk("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_perf_s", {16'b0, perf_stall_cnt}, 32'd0);
        chk("rst_perf_d", {16'b0, perf_dbg_cnt}, 32'd0);
        next_cyc();
        reset = 1'b0;
        idle_in();

        // ---- table vectors, one cycle each
        //          cr    cw    ca        cd        dv    dw    da        dd        rdy   stl   wr    addr      din       op    crd       rv    rd
        vt[0] = '{1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 1'b0, 32'h000, 32'h00, 3'd2, 32'h00, 1'b0, 32'h00};
        vt[1] = '{1'b1, 1'b1, 32'h800, 32'h0a, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 1'b1, 32'h800, 32'h0a, 3'd2, 32'h00, 1'b0, 32'h00};
        vt[2] = '{1'b0, 1'b0, 32'h000, 32'h00, 1'b1, 1'b0, 32'h800, 32'h00, 1'b1, 1'b0, 1'b0, 32'h800, 32'h00, 3'd5, 32'h0a, 1'b0, 32'h00};
        vt[3] = '{1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 1'b0, 32'h000, 32'h00, 3'd2, 32'h00, 1'b1, 32'h0a};
        vt[4] = '{1'b0, 1'b0, 32'h000, 32'h00, 1'b1, 1'b1, 32'h804, 32'h55, 1'b1, 1'b0, 1'b1, 32'h804, 32'h55, 3'd5, 32'h00, 1'b0, 32'h00};
        vt[5] = '{1'b1, 1'b0, 32'h800, 32'h00, 1'b1, 1'b0, 32'h804, 32'h00, 1'b0, 1'b0, 1'b0, 32'h800, 32'h00, 3'd2, 32'h0a, 1'b0, 32'h00};
        vt[6] = '{1'b0, 1'b0, 32'h000, 32'h00, 1'b1, 1'b0, 32'h804, 32'h00, 1'b1, 1'b0, 1'b0, 32'h804, 32'h00, 3'd5, 32'h55, 1'b0, 32'h00};
        vt[7] = '{1'b1, 1'b1, 32'h808, 32'h77, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 1'b1, 32'h808, 32'h77, 3'd2, 32'h00, 1'b1, 32'h55};
        vt[8] = '{1'b1, 1'b0, 32'h808, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0, 1'b0, 1'b0, 32'h808, 32'h00, 3'd2, 32'h77, 1'b0, 32'h00};

        for (int i = 0; i < 9; i++) begin
            cpu_req = vt[i].cr; cpu_wr_en = vt[i].cw; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
            dbg_valid = vt[i].dv; dbg_wr_en = vt[i].dw; dbg_addr = vt[i].da; dbg_wdata = vt[i].dd;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {31'b0, dbg_ready}, {31'b0, vt[i].e_rdy});
            chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vt[i].e_stall});
            chk($sformatf("v%0d_memwr", i), {31'b0, mem_wr_en}, {31'b0, vt[i].e_wr});
            chk($sformatf("v%0d_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_din", i), mem_data_in, vt[i].e_din);
            chk($sformatf("v%0d_op", i), {29'b0, mem_op}, {29'b0, vt[i].e_op});
            chk($sformatf("v%0d_cpurd", i), cpu_rdata, vt[i].e_crd);
            chk($sformatf("v%0d_rvalid", i), {31'b0, dbg_rvalid}, {31'b0, vt[i].e_rv});
            if (vt[i].e_rv) chk($sformatf("v%0d_rdata", i), dbg_rdata, vt[i].e_rd);
            next_cyc();
        end
        idle_in();
        next_cyc();

        // ---- starvation: CPU reads continuously, debug reads 0x808 from cycle 0
        cpu_req = 1'b1; cpu_addr = 32'h900;
        dbg_valid = 1'b1; dbg_addr = 32'h808;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("starv_c%0d_ready", c), {31'b0, dbg_ready}, (c == MAX_WAIT) ? 32'd1 : 32'd0);
            chk($sformatf("starv_c%0d_stall", c), {31'b0, cpu_stall}, (c == MAX_WAIT) ? 32'd1 : 32'd0);
            if (c == MAX_WAIT) chk("starv_addr", mem_addr, 32'h808);
            if (c == MAX_WAIT + 1) begin
                chk("starv_addr_cpu", mem_addr, 32'h900);
                chk("starv_rvalid", {31'b0, dbg_rvalid}, 32'd1);
                chk("starv_rdata", dbg_rdata, 32'h77);
            end
            next_cyc();
        end
        idle_in();
        next_cyc();

        // ---- stalled CPU store: CPU reads, switches to a store on the forced-grant cycle
        cpu_req = 1'b1; cpu_addr = 32'h900;
        dbg_valid = 1'b1; dbg_addr = 32'h810;
        for (int c = 0; c < MAX_WAIT; c++) next_cyc();
        cpu_wr_en = 1'b1; cpu_addr = 32'h810; cpu_wdata = 32'hbeef;
        @(negedge clk);
        chk("sst_ready", {31'b0, dbg_ready}, 32'd1);
        chk("sst_stall", {31'b0, cpu_stall}, 32'd1);
        chk("sst_memwr_blocked", {31'b0, mem_wr_en}, 32'd0);
        next_cyc();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("sst_stall_drop", {31'b0, cpu_stall}, 32'd0);
        chk("sst_memwr_land", {31'b0, mem_wr_en}, 32'd1);
        chk("sst_land_addr", mem_addr, 32'h810);
        chk("sst_land_data", mem_data_in, 32'hbeef);
        chk("sst_dbg_old", dbg_rdata, 32'h0);
        next_cyc();
        cpu_wr_en = 1'b0;
        @(negedge clk);
        chk("sst_readback", cpu_rdata, 32'hbeef);
        next_cyc();
        idle_in();
        next_cyc();

        // ---- reset while wait_cnt=5: grant must take the full MAX_WAIT again
        cpu_req = 1'b1; cpu_addr = 32'h900;
        dbg_valid = 1'b1; dbg_addr = 32'h800;
        for (int c = 0; c < 5; c++) next_cyc();
        reset = 1'b1; cpu_wr_en = 1'b1;
        @(negedge clk);
        chk("rmid_ready", {31'b0, dbg_ready}, 32'd0);
        chk("rmid_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rmid_memwr", {31'b0, mem_wr_en}, 32'd0);
        next_cyc();
        reset = 1'b0; cpu_wr_en = 1'b0;
        grant_at = -1;
        for (int c = 0; c < 20 && grant_at < 0; c++) begin
            @(negedge clk);
            if (dbg_ready) grant_at = c;
            next_cyc();
        end
        chk("rmid_grant_cycle", grant_at, MAX_WAIT);
        idle_in();
        next_cyc();

        // ---- reset with a debug read in flight drops rvalid
        dbg_valid = 1'b1; dbg_addr = 32'h800;
        @(negedge clk);
        chk("rinf_ready", {31'b0, dbg_ready}, 32'd1);
        next_cyc();
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        chk("rinf_rv_before", {31'b0, dbg_rvalid}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("rinf_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rinf_rdata", dbg_rdata, 32'd0);
        // debug request raised with reset high: no grant, no rvalid afterwards
        dbg_valid = 1'b1;
        @(negedge clk);
        chk("rinf_ready_rst", {31'b0, dbg_ready}, 32'd0);
        next_cyc();
        reset = 1'b0;
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("rinf_rv_none", {31'b0, dbg_rvalid}, 32'd0);
        next_cyc();

        // ---- perf counters: three forced grants under continuous cpu_req
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h900;
        dbg_valid = 1'b1; dbg_addr = 32'h800;
        for (int c = 0; c < 3 * (MAX_WAIT + 1); c++) next_cyc();
        idle_in();
        @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", {16'b0, perf_stall_cnt}, 32'd3);
        chk("perf_dbg", {16'b0, perf_dbg_cnt}, 32'd3);
`else
        chk("perf_stall_off", {16'b0, perf_stall_cnt}, 32'd0);
        chk("perf_dbg_off", {16'b0, perf_dbg_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
